// File: rtl/apu_sequential_mixer_pkg.sv
// Shared types and helpers for the APU sequential mixer.
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } mixer_state_t;

  localparam int APU_DEFAULT_CHANNELS = 4;

  // Accumulator width large enough that the sum of all channels can never wrap.
  function automatic int mix_acc_width(input int num_channels, input int sample_width);
    return sample_width + $clog2(num_channels) + 1;
  endfunction

endpackage

// File: rtl/apu_sequential_mixer_if.sv
// Bus between the channel generators, the mixer and the DAC/PWM stage.
// Optional macro APU_MIXER_PEAK_EN adds the peak-meter clear input and peak output.
interface apu_sequential_mixer_if
  import apu_pkg::*;
#(
  parameter int NUM_CHANNELS = APU_DEFAULT_CHANNELS,
  parameter int SAMPLE_WIDTH = 9,
  parameter int VOL_WIDTH    = 4,
  parameter int OUT_WIDTH    = 11
);

  logic                              i_sample_stb;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_samples;
  logic [NUM_CHANNELS-1:0]           i_mixer;
  logic [NUM_CHANNELS*VOL_WIDTH-1:0] i_volume;
  logic [OUT_WIDTH-1:0]              o_sample;
  logic                              o_sample_stb;
  logic                              o_busy;
  logic                              o_clip;
  logic                              o_overrun;
`ifdef APU_MIXER_PEAK_EN
  logic                              i_peak_clr;
  logic [OUT_WIDTH-1:0]              o_peak;

  modport master (
    output i_sample_stb, i_samples, i_mixer, i_volume, i_peak_clr,
    input  o_sample, o_sample_stb, o_busy, o_clip, o_overrun, o_peak
  );

  modport slave (
    input  i_sample_stb, i_samples, i_mixer, i_volume, i_peak_clr,
    output o_sample, o_sample_stb, o_busy, o_clip, o_overrun, o_peak
  );
`else
  modport master (
    output i_sample_stb, i_samples, i_mixer, i_volume,
    input  o_sample, o_sample_stb, o_busy, o_clip, o_overrun
  );

  modport slave (
    input  i_sample_stb, i_samples, i_mixer, i_volume,
    output o_sample, o_sample_stb, o_busy, o_clip, o_overrun
  );
`endif

endinterface

// File: rtl/apu_sequential_mixer_scaler.sv
// Per-channel volume scaler: all-ones volume is unity gain, otherwise (s*v) >> VOL_WIDTH.
module apu_channel_scaler
  import apu_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 9,
  parameter int VOL_WIDTH    = 4
) (
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic [VOL_WIDTH-1:0]    i_volume,
  output logic [SAMPLE_WIDTH-1:0] o_scaled
);

  localparam int PROD_W = SAMPLE_WIDTH + VOL_WIDTH;

  logic [PROD_W-1:0] w_product;

  // Full-volume bypass keeps full scale reachable; other volumes truncate the product.
  always_comb begin
    w_product = PROD_W'(i_sample) * PROD_W'(i_volume);
    if (&i_volume) begin
      o_scaled = i_sample;
    end else begin
      o_scaled = w_product[PROD_W-1:VOL_WIDTH];
    end
  end

endmodule

// File: rtl/apu_sequential_mixer.sv
// N-channel sequential mixer: snapshot on strobe, accumulate one channel per clock,
// then saturate and publish with a one-cycle valid strobe.
// Optional macro APU_MIXER_PEAK_EN builds a peak-hold meter on the published samples.
module apu_sequential_mixer
  import apu_pkg::*;
#(
  parameter int NUM_CHANNELS = APU_DEFAULT_CHANNELS,
  parameter int SAMPLE_WIDTH = 9,
  parameter int VOL_WIDTH    = 4,
  parameter int OUT_WIDTH    = 11
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  apu_sequential_mixer_if.slave  bus
);

  localparam int ACC_W = mix_acc_width(NUM_CHANNELS, SAMPLE_WIDTH);
  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CMP_W = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;

  mixer_state_t r_state;
  mixer_state_t w_next_state;
  logic         w_load;
  logic         w_accum;
  logic         w_output;

  logic [SAMPLE_WIDTH-1:0] r_samples [NUM_CHANNELS];
  logic [VOL_WIDTH-1:0]    r_volume  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_mask;

  logic [IDX_W-1:0]        r_ch_idx;
  logic                    w_last;
  logic [ACC_W-1:0]        r_acc;

  logic [SAMPLE_WIDTH-1:0] w_sel_sample;
  logic [VOL_WIDTH-1:0]    w_sel_volume;
  logic [SAMPLE_WIDTH-1:0] w_scaled;
  logic [SAMPLE_WIDTH-1:0] w_gated;

  logic [CMP_W-1:0]        w_acc_ext;
  logic                    w_clip;
  logic [OUT_WIDTH-1:0]    w_sat;

  logic [OUT_WIDTH-1:0]    r_sample;
  logic                    r_sample_stb;
  logic                    r_clip;
  logic                    r_overrun;

  assign w_last       = (r_ch_idx == IDX_W'(NUM_CHANNELS - 1));
  assign w_sel_sample = r_samples[r_ch_idx];
  assign w_sel_volume = r_volume[r_ch_idx];
  assign w_gated      = r_mask[r_ch_idx] ? w_scaled : '0;

  assign w_acc_ext    = CMP_W'(r_acc);
  assign w_clip       = (w_acc_ext > CMP_W'({OUT_WIDTH{1'b1}}));
  assign w_sat        = w_clip ? {OUT_WIDTH{1'b1}} : OUT_WIDTH'(r_acc);

  apu_channel_scaler #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .VOL_WIDTH    (VOL_WIDTH)
  ) u_scaler (
    .i_sample (w_sel_sample),
    .i_volume (w_sel_volume),
    .o_scaled (w_scaled)
  );

  // State register; reset aborts any mix in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic plus the load/accumulate/publish controls for the datapath.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_accum      = 1'b0;
    w_output     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_sample_stb) begin
          w_load       = 1'b1;
          w_next_state = ACCUM;
        end
      end
      ACCUM: begin
        w_accum = 1'b1;
        if (w_last) begin
          w_next_state = OUTPUT;
        end
      end
      OUTPUT: begin
        w_output     = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Snapshot of all mixing inputs so later input changes cannot disturb this mix.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_samples[k] <= '0;
        r_volume[k]  <= '0;
      end
      r_mask <= '0;
    end else if (w_load) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_samples[k] <= bus.i_samples[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        r_volume[k]  <= bus.i_volume[k*VOL_WIDTH +: VOL_WIDTH];
      end
      r_mask <= bus.i_mixer;
    end
  end

  // Channel walk and running sum; the index holds on the last channel until the next load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_ch_idx <= '0;
    end else if (w_load) begin
      r_acc    <= '0;
      r_ch_idx <= '0;
    end else if (w_accum) begin
      r_acc <= r_acc + ACC_W'(w_gated);
      if (!w_last) begin
        r_ch_idx <= r_ch_idx + IDX_W'(1);
      end
    end
  end

  // Published sample is held between mixes; strobes and flags are single-cycle pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample     <= '0;
      r_sample_stb <= 1'b0;
      r_clip       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sample_stb <= w_output;
      r_clip       <= w_output && w_clip;
      r_overrun    <= bus.i_sample_stb && (r_state != IDLE);
      if (w_output) begin
        r_sample <= w_sat;
      end
    end
  end

  assign bus.o_sample     = r_sample;
  assign bus.o_sample_stb = r_sample_stb;
  assign bus.o_clip       = r_clip;
  assign bus.o_overrun    = r_overrun;
  assign bus.o_busy       = (r_state != IDLE);

`ifdef APU_MIXER_PEAK_EN
  logic [OUT_WIDTH-1:0] r_peak;

  // Peak hold of published samples; a clear coinciding with a publish keeps the new sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_peak <= '0;
    end else if (w_output) begin
      if (bus.i_peak_clr || (w_sat > r_peak)) begin
        r_peak <= w_sat;
      end
    end else if (bus.i_peak_clr) begin
      r_peak <= '0;
    end
  end

  assign bus.o_peak = r_peak;
`endif

endmodule

// File: tb/tb_apu_sequential_mixer.sv
// Self-checking bench for apu_sequential_mixer with a behavioural mix model.
// Peak-meter scenario is built only when APU_MIXER_PEAK_EN is defined.
module tb_apu_sequential_mixer;
  import apu_pkg::*;

  localparam int NCH  = 4;
  localparam int SW   = 9;
  localparam int VW   = 4;
  localparam int OW   = 11;
  localparam int OW10 = 10;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  apu_sequential_mixer_if #(.NUM_CHANNELS(NCH), .SAMPLE_WIDTH(SW), .VOL_WIDTH(VW), .OUT_WIDTH(OW))   bus();
  apu_sequential_mixer_if #(.NUM_CHANNELS(NCH), .SAMPLE_WIDTH(SW), .VOL_WIDTH(VW), .OUT_WIDTH(OW10)) bus10();

  apu_sequential_mixer #(.NUM_CHANNELS(NCH), .SAMPLE_WIDTH(SW), .VOL_WIDTH(VW), .OUT_WIDTH(OW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  apu_sequential_mixer #(.NUM_CHANNELS(NCH), .SAMPLE_WIDTH(SW), .VOL_WIDTH(VW), .OUT_WIDTH(OW10)) dut10 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus10)
  );

  // Reference gain: full-scale volume passes the sample, otherwise multiply and divide by 2^VW.
  function automatic int scale_ref(input int s, input int v);
    if (v == (1 << VW) - 1) return s;
    return (s * v) / (1 << VW);
  endfunction

  // Reference unsaturated sum over enabled channels.
  function automatic int mix_ref(input int s[NCH], input int v[NCH], input int m);
    int sum = 0;
    for (int k = 0; k < NCH; k++) begin
      if ((m >> k) & 1) sum += scale_ref(s[k], v[k]);
    end
    return sum;
  endfunction

  function automatic int sat_ref(input int sum, input int ow);
    int maxv = (1 << ow) - 1;
    return (sum > maxv) ? maxv : sum;
  endfunction

  task automatic applyStimulus(input int s[NCH], input int v[NCH], input int m);
    @(negedge i_clk);
    for (int k = 0; k < NCH; k++) begin
      bus.i_samples[k*SW +: SW] = SW'(s[k]);
      bus.i_volume[k*VW +: VW]  = VW'(v[k]);
    end
    bus.i_mixer      = NCH'(m);
    bus.i_sample_stb = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_sample_stb = 1'b0;
  endtask

  task automatic waitOutput(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_sample_stb) begin
        seen = 1'b1;
        lat  = c;
      end
    end
  endtask

  task automatic test_reset();
    #1 i_rst = 1'b1;
    #1;
    checks++; if (bus.o_sample !== '0)    begin errors++; $display("[TB] FAIL reset_sample got %0d want 0", bus.o_sample); end
    checks++; if (bus.o_sample_stb !== 1'b0) begin errors++; $display("[TB] FAIL reset_stb got %b want 0", bus.o_sample_stb); end
    checks++; if (bus.o_busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.o_busy); end
    checks++; if (bus.o_clip !== 1'b0)    begin errors++; $display("[TB] FAIL reset_clip got %b want 0", bus.o_clip); end
    checks++; if (bus.o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got %b want 0", bus.o_overrun); end
    checks++; if (bus10.o_busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy10 got %b want 0", bus10.o_busy); end
`ifdef APU_MIXER_PEAK_EN
    checks++; if (bus.o_peak !== '0)      begin errors++; $display("[TB] FAIL reset_peak got %0d want 0", bus.o_peak); end
`endif
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_basic();
    int s[NCH] = '{10, 50, 200, 100};
    int v[NCH] = '{15, 15, 15, 15};
    int busyCnt = 0, stbCnt = 0, stbAt = 0, got = -1;
    applyStimulus(s, v, 4'b1111);
    if (bus.o_busy) busyCnt++;
    for (int c = 1; c <= 8; c++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_busy) busyCnt++;
      if (bus.o_sample_stb) begin
        stbCnt++;
        if (stbAt == 0) begin stbAt = c; got = int'(bus.o_sample); end
      end
    end
    checks++; if (got !== 360)   begin errors++; $display("[TB] FAIL basic_sample got %0d want 360", got); end
    checks++; if (stbAt !== 5)   begin errors++; $display("[TB] FAIL basic_latency got %0d want 5", stbAt); end
    checks++; if (stbCnt !== 1)  begin errors++; $display("[TB] FAIL basic_stb_width got %0d want 1", stbCnt); end
    checks++; if (busyCnt !== 5) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 5", busyCnt); end
    checks++; if (bus.o_sample !== 11'd360) begin errors++; $display("[TB] FAIL basic_hold got %0d want 360", bus.o_sample); end
  endtask

  task automatic test_volume_mask();
    int s[NCH] = '{200, 200, 100, 7};
    int v[NCH] = '{8, 0, 15, 15};
    int lat;
    bit seen;
    applyStimulus(s, v, 4'b1011);
    waitOutput(lat, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL volmask_timeout got no strobe want strobe"); end
    checks++; if (bus.o_sample !== 11'd107) begin errors++; $display("[TB] FAIL volmask_sample got %0d want 107", bus.o_sample); end
    checks++; if (bus.o_clip !== 1'b0) begin errors++; $display("[TB] FAIL volmask_clip got %b want 0", bus.o_clip); end
  endtask

  task automatic test_saturation();
    int cs[3][NCH] = '{'{511, 511, 511, 511}, '{511, 511, 1, 0}, '{511, 511, 2, 0}};
    int wantSample, wantClip, gotSample, gotClip;
    bit seen;
    for (int t = 0; t < 3; t++) begin
      wantSample = 1023;
      wantClip   = (cs[t][0] + cs[t][1] + cs[t][2] + cs[t][3]) > 1023 ? 1 : 0;
      @(negedge i_clk);
      for (int k = 0; k < NCH; k++) begin
        bus10.i_samples[k*SW +: SW] = SW'(cs[t][k]);
        bus10.i_volume[k*VW +: VW]  = '1;
      end
      bus10.i_mixer      = '1;
      bus10.i_sample_stb = 1'b1;
      @(posedge i_clk);
      #1;
      bus10.i_sample_stb = 1'b0;
      seen = 1'b0;
      gotSample = -1;
      gotClip   = -1;
      for (int c = 1; c <= 20 && !seen; c++) begin
        @(posedge i_clk);
        #1;
        if (bus10.o_sample_stb) begin
          seen      = 1'b1;
          gotSample = int'(bus10.o_sample);
          gotClip   = int'(bus10.o_clip);
        end
      end
      checks++; if (gotSample !== wantSample) begin errors++; $display("[TB] FAIL sat_sample case %0d got %0d want %0d", t, gotSample, wantSample); end
      checks++; if (gotClip !== wantClip) begin errors++; $display("[TB] FAIL sat_clip case %0d got %0d want %0d", t, gotClip, wantClip); end
      @(posedge i_clk);
      #1;
      checks++; if (bus10.o_clip !== 1'b0) begin errors++; $display("[TB] FAIL sat_clip_pulse case %0d got %b want 0", t, bus10.o_clip); end
    end
  endtask

  task automatic test_overrun();
    int sa[NCH] = '{100, 20, 300, 40};
    int va[NCH] = '{15, 8, 4, 15};
    int want = sat_ref(mix_ref(sa, va, 4'b1111), OW);
    int lat, extra;
    bit seen;
    applyStimulus(sa, va, 4'b1111);
    @(negedge i_clk);
    for (int k = 0; k < NCH; k++) begin
      bus.i_samples[k*SW +: SW] = 9'd500;
      bus.i_volume[k*VW +: VW]  = 4'hF;
    end
    bus.i_mixer = 4'b1111;
    @(negedge i_clk);
    bus.i_sample_stb = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_sample_stb = 1'b0;
    checks++; if (bus.o_overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_pulse got %b want 1", bus.o_overrun); end
    @(posedge i_clk);
    #1;
    checks++; if (bus.o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_width got %b want 0", bus.o_overrun); end
    waitOutput(lat, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL overrun_timeout got no strobe want strobe"); end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL overrun_latency got %0d want 2", lat); end
    checks++; if (int'(bus.o_sample) !== want) begin errors++; $display("[TB] FAIL overrun_sample got %0d want %0d", bus.o_sample, want); end
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_sample_stb || bus.o_busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL overrun_no_second_mix got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_midmix();
    int s1[NCH] = '{300, 301, 302, 303};
    int s2[NCH] = '{100, 100, 100, 100};
    int v[NCH]  = '{15, 15, 15, 15};
    int lat, stray;
    bit seen;
    applyStimulus(s1, v, 4'b1111);
    @(posedge i_clk);
    @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    checks++; if (bus.o_sample !== '0)  begin errors++; $display("[TB] FAIL midreset_sample got %0d want 0", bus.o_sample); end
    checks++; if (bus.o_busy !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", bus.o_busy); end
    @(negedge i_clk);
    i_rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_sample_stb) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL midreset_stray_stb got %0d want 0", stray); end
    applyStimulus(s2, v, 4'b1111);
    waitOutput(lat, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL midreset_timeout got no strobe want strobe"); end
    checks++; if (bus.o_sample !== 11'd400) begin errors++; $display("[TB] FAIL midreset_sample_after got %0d want 400", bus.o_sample); end
  endtask

  task automatic test_random();
    int s[NCH], v[NCH];
    int m, sum, lat;
    bit seen;
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < NCH; k++) begin
        s[k] = int'($urandom_range(0, 511));
        case ($urandom_range(0, 3))
          0:       v[k] = 0;
          1:       v[k] = 15;
          default: v[k] = int'($urandom_range(0, 15));
        endcase
      end
      m   = int'($urandom_range(0, 15));
      sum = mix_ref(s, v, m);
      applyStimulus(s, v, m);
      waitOutput(lat, seen);
      checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL rand_latency it %0d got %0d want 5", it, lat); end
      checks++; if (int'(bus.o_sample) !== sat_ref(sum, OW)) begin errors++; $display("[TB] FAIL rand_sample it %0d got %0d want %0d", it, bus.o_sample, sat_ref(sum, OW)); end
      checks++; if (int'(bus.o_clip) !== ((sum > 2047) ? 1 : 0)) begin errors++; $display("[TB] FAIL rand_clip it %0d got %b want %0d", it, bus.o_clip, (sum > 2047) ? 1 : 0); end
    end
  endtask

  task automatic test_back_to_back();
    int s[NCH], v[NCH];
    int lat, want;
    bit seen;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < NCH; k++) begin
        s[k] = 50 * (it + 1) + k;
        v[k] = 15 - it;
      end
      want = sat_ref(mix_ref(s, v, 4'b1111), OW);
      applyStimulus(s, v, 4'b1111);
      checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept it %0d got busy %b want 1", it, bus.o_busy); end
      checks++; if (bus.o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun it %0d got %b want 0", it, bus.o_overrun); end
      waitOutput(lat, seen);
      checks++; if (int'(bus.o_sample) !== want) begin errors++; $display("[TB] FAIL b2b_sample it %0d got %0d want %0d", it, bus.o_sample, want); end
    end
  endtask

`ifdef APU_MIXER_PEAK_EN
  task automatic test_peak();
    int vals[4] = '{300, 500, 200, 123};
    int s[NCH], v[NCH];
    int refPeak, lat, clrAt;
    bit seen;
    @(negedge i_clk);
    bus.i_peak_clr = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_peak_clr = 1'b0;
    refPeak = 0;
    checks++; if (bus.o_peak !== '0) begin errors++; $display("[TB] FAIL peak_clear_initial got %0d want 0", bus.o_peak); end
    v = '{15, 15, 15, 15};
    for (int t = 0; t < 3; t++) begin
      s = '{vals[t], 0, 0, 0};
      applyStimulus(s, v, 4'b0001);
      waitOutput(lat, seen);
      if (vals[t] > refPeak) refPeak = vals[t];
      checks++; if (int'(bus.o_peak) !== refPeak) begin errors++; $display("[TB] FAIL peak_track step %0d got %0d want %0d", t, bus.o_peak, refPeak); end
    end
    @(negedge i_clk);
    bus.i_peak_clr = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_peak_clr = 1'b0;
    checks++; if (bus.o_peak !== '0) begin errors++; $display("[TB] FAIL peak_clear got %0d want 0", bus.o_peak); end
    s = '{vals[3], 0, 0, 0};
    applyStimulus(s, v, 4'b0001);
    for (clrAt = 0; clrAt < 4; clrAt++) @(posedge i_clk);
    @(negedge i_clk);
    bus.i_peak_clr = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_peak_clr = 1'b0;
    checks++; if (bus.o_sample_stb !== 1'b1) begin errors++; $display("[TB] FAIL peak_coincide_stb got %b want 1", bus.o_sample_stb); end
    checks++; if (int'(bus.o_peak) !== vals[3]) begin errors++; $display("[TB] FAIL peak_coincide got %0d want %0d", bus.o_peak, vals[3]); end
  endtask
`endif

  // Safety net so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got time limit want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_sample_stb   = 1'b0;
    bus.i_samples      = '0;
    bus.i_mixer        = '0;
    bus.i_volume       = '0;
    bus10.i_sample_stb = 1'b0;
    bus10.i_samples    = '0;
    bus10.i_mixer      = '0;
    bus10.i_volume     = '0;
`ifdef APU_MIXER_PEAK_EN
    bus.i_peak_clr     = 1'b0;
    bus10.i_peak_clr   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_volume_mask();
    test_saturation();
    test_overrun();
    test_reset_midmix();
    test_random();
    test_back_to_back();
`ifdef APU_MIXER_PEAK_EN
    test_peak();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
